selmap_sync_fifo: RTL

// Single-clock, parametrised FIFO for the SelectMAP datapath. Buffers bitstream/readback words between the AXI

---
 rtl/selmap_fifo_pkg.sv | 40 ++++
 rtl/selmap_fifo_ram.sv | 46 ++++
 rtl/selmap_sync_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/selmap_fifo_pkg.sv
// Shared constants, flag decode and elaboration-time parameter checks for the
// SelectMAP single-clock FIFO.
`ifndef SELMAP_FIFO_PKG_SV
`define SELMAP_FIFO_PKG_SV

// Elaboration-time guard: instantiates a labelled block that raises $error when cond is false.
`define SELMAP_FIFO_PARAM_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

package selmap_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic fifo_flags_t decode_flags(input int lvl, input int depth,
                                                 input int af_thresh, input int ae_thresh);
        fifo_flags_t f;
        f.full         = (lvl == depth);
        f.empty        = (lvl == 0);
        f.almost_full  = (lvl >= af_thresh);
        f.almost_empty = (lvl <= ae_thresh);
        return f;
    endfunction

endpackage

`endif

// File: rtl/selmap_fifo_ram.sv
// Simple dual-port storage for the SelectMAP FIFO: synchronous write, read port
// either registered (REG_OUT=1) or combinational (REG_OUT=0).
module selmap_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int REG_OUT    = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [DATA_WIDTH-1:0] rd_data_p1;

        // Read stage boundary: output register holds the last word read until the next read.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_p1 <= '0;
            end else if (rd_en) begin
                rd_data_p1 <= mem[rd_addr];
            end
        end

        assign rd_data = rd_data_p1;
    end else begin : g_async_out
        logic unused_ctrl;
        assign unused_ctrl = ^{rst, rd_en};
        assign rd_data     = mem[rd_addr];
    end

endmodule

// File: rtl/selmap_sync_fifo.sv
// Single-clock FIFO between the AXI side and the SelectMAP engine, with standard
// or first-word-fall-through reads, fill level, threshold flags and sticky errors.
module selmap_sync_fifo
    import selmap_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    `SELMAP_FIFO_PARAM_CHECK(g_chk_depth, is_pow2(FIFO_DEPTH) && (FIFO_DEPTH >= 2),
                             "FIFO_DEPTH must be a power of two and at least 2")
    `SELMAP_FIFO_PARAM_CHECK(g_chk_mode, (FWFT == FIFO_MODE_STD) || (FWFT == FIFO_MODE_FWFT),
                             "FWFT must be 0 or 1")
    `SELMAP_FIFO_PARAM_CHECK(g_chk_af, (AF_THRESH >= 1) && (AF_THRESH <= FIFO_DEPTH - 1),
                             "AF_THRESH must be in 1..FIFO_DEPTH-1")
    `SELMAP_FIFO_PARAM_CHECK(g_chk_ae, (AE_THRESH >= 0) && (AE_THRESH <= FIFO_DEPTH - 1),
                             "AE_THRESH must be in 0..FIFO_DEPTH-1")

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_flags_t           flags;

    // All status is decoded from the registered level, so it lags the accepting edge by one cycle.
    assign flags  = decode_flags(int'(level_q), FIFO_DEPTH, AF_THRESH, AE_THRESH);
    assign wr_acc = wr_en && !flags.full;
    assign rd_acc = rd_en && !flags.empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // A fresh rejection wins over a same-cycle clear so no error event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && flags.full) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (rd_en && flags.empty) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    selmap_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .REG_OUT    ((FWFT == FIFO_MODE_FWFT) ? 0 : 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rd_data_valid = !flags.empty;
    end else begin : g_std
        logic vld_p1;

        // Read stage boundary: valid pulses alongside the registered RAM output.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
            end
        end

        assign rd_data_valid = vld_p1;
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
